// File: rtl/mem64_arbiter.sv
// mem64_arbiter
//   Two-requester round-robin arbiter and sequencer for the 64-byte memory
//   array. It serialises byte read/write requests from ports A and B, plus a
//   whole-memory clear, onto the memory's D_IN/ADDR/R_ENABLE/W_ENABLE/RESET
//   pins. It returns read data and a one-cycle ACK to the winning requester.
//
// Ports
//   CLK, RESET         rising-edge clock, asynchronous active-low reset
//   A_REQ/A_WE/A_ADDR/A_WDATA   requester A command (REQ held until A_ACK)
//   A_ACK, A_RDATA     A completion pulse and read data (held until next A read)
//   B_*                same as A, for requester B
//   CLR_REQ, CLR_ACK   clear-memory request / completion pulse
//   MEM_D_IN, MEM_ADDR, MEM_R_ENABLE, MEM_W_ENABLE, MEM_RESET   to memory
//   MEM_D_OUT          read data from memory
//
// All outputs are registered. Each output is loaded on the edge that enters
// the state it belongs to, so it is valid for that whole state.
module mem64_arbiter #(
    parameter int RD_LAT = 1,
    parameter int AW     = 6,
    parameter int DW     = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_WDATA,
    output logic          A_ACK,
    output logic [DW-1:0] A_RDATA,
    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_WDATA,
    output logic          B_ACK,
    output logic [DW-1:0] B_RDATA,
    input  logic          CLR_REQ,
    output logic          CLR_ACK,
    output logic [DW-1:0] MEM_D_IN,
    output logic [7:0]    MEM_ADDR,
    output logic          MEM_R_ENABLE,
    output logic          MEM_W_ENABLE,
    output logic          MEM_RESET,
    input  logic [DW-1:0] MEM_D_OUT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_CLR,
        S_DONE
    } state_t;

    // WAIT lasts RD_LAT cycles; the counter runs from RD_LAT-1 down to 0.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_t     state;
    logic       last_b;     // 1: B was granted last, so A wins the next tie
    logic       granted_b;  // port owning the current transaction
    logic       we_q;       // latched write/read flag of the current grant
    logic [1:0] wait_cnt;

    // Requester address zero-extended onto the 8-bit memory address bus.
    function automatic logic [7:0] mem_addr_of(input logic [AW-1:0] a);
        logic [7:0] r;
        r         = '0;
        r[AW-1:0] = a;
        return r;
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= S_IDLE;
            last_b       <= 1'b1;
            granted_b    <= 1'b0;
            we_q         <= 1'b0;
            wait_cnt     <= 2'd0;
            A_ACK        <= 1'b0;
            A_RDATA      <= '0;
            B_ACK        <= 1'b0;
            B_RDATA      <= '0;
            CLR_ACK      <= 1'b0;
            MEM_D_IN     <= '0;
            MEM_ADDR     <= '0;
            MEM_R_ENABLE <= 1'b0;
            MEM_W_ENABLE <= 1'b0;
            MEM_RESET    <= 1'b0;
        end else begin
            // Pulse-type outputs default low; only the entering state raises them.
            A_ACK        <= 1'b0;
            B_ACK        <= 1'b0;
            CLR_ACK      <= 1'b0;
            MEM_R_ENABLE <= 1'b0;
            MEM_W_ENABLE <= 1'b0;
            MEM_RESET    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (CLR_REQ) begin
                        // Clear has priority and does not move the RR pointer.
                        state     <= S_CLR;
                        MEM_RESET <= 1'b1;
                    end else if (A_REQ && (!B_REQ || last_b)) begin
                        state        <= S_CMD;
                        granted_b    <= 1'b0;
                        last_b       <= 1'b0;
                        we_q         <= A_WE;
                        MEM_ADDR     <= mem_addr_of(A_ADDR);
                        MEM_D_IN     <= A_WDATA;
                        MEM_W_ENABLE <= A_WE;
                        MEM_R_ENABLE <= ~A_WE;
                    end else if (B_REQ) begin
                        state        <= S_CMD;
                        granted_b    <= 1'b1;
                        last_b       <= 1'b1;
                        we_q         <= B_WE;
                        MEM_ADDR     <= mem_addr_of(B_ADDR);
                        MEM_D_IN     <= B_WDATA;
                        MEM_W_ENABLE <= B_WE;
                        MEM_R_ENABLE <= ~B_WE;
                    end
                end

                S_CMD: begin
                    if (we_q) begin
                        state <= S_DONE;
                        A_ACK <= ~granted_b;
                        B_ACK <= granted_b;
                    end else begin
                        state    <= S_WAIT;
                        wait_cnt <= WAIT_INIT;
                    end
                end

                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        // Last WAIT edge: memory output is valid now.
                        state <= S_DONE;
                        if (granted_b) begin
                            B_RDATA <= MEM_D_OUT;
                            B_ACK   <= 1'b1;
                        end else begin
                            A_RDATA <= MEM_D_OUT;
                            A_ACK   <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end

                S_CLR: begin
                    state   <= S_DONE;
                    CLR_ACK <= 1'b1;
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
